// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: pin synchronisers, clock glitch filter,
// 11-bit frame deserialiser with parity/stop checks and a frame timeout.
`timescale 1ns/1ps
module ps2_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] data,
    output logic       data_en,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned FCNT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BCNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic              clk_s1, clk_s2, dat_s1, dat_s2;
    logic              filt_clk, filt_prev;
    logic [FCNT_W-1:0] filt_cnt;
    logic              fall_c;

    state_t            state, state_nxt;
    logic [BCNT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic [7:0]        shift, shift_nxt;
    logic              par_bit, par_nxt;
    logic [TCNT_W-1:0] tmo_cnt, tmo_nxt;
    logic              tmo_hit_c;
    logic [7:0]        data_nxt;
    logic              data_en_nxt, perr_nxt, ferr_nxt, busy_nxt;

    // Two-flop synchronisers; idle bus level is high
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= PS2_CLK;
            clk_s2 <= clk_s1;
            dat_s1 <= PS2_DAT;
            dat_s2 <= dat_s1;
        end
    end

    // Glitch filter: follow synced clock only after FILTER_LEN differing samples
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            filt_prev <= filt_clk;
            if (clk_s2 != filt_clk) begin
                if (filt_cnt == FCNT_W'(FILTER_LEN - 1)) begin
                    filt_clk <= clk_s2;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + FCNT_W'(1);
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign fall_c = filt_prev & ~filt_clk;

    // State and output registers
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            tmo_cnt    <= '0;
            data       <= '0;
            data_en    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shift      <= shift_nxt;
            par_bit    <= par_nxt;
            tmo_cnt    <= tmo_nxt;
            data       <= data_nxt;
            data_en    <= data_en_nxt;
            parity_err <= perr_nxt;
            frame_err  <= ferr_nxt;
            busy       <= busy_nxt;
        end
    end

    // Next-state, timeout and output decode; a fall event beats a timeout
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        par_nxt     = par_bit;
        data_nxt    = data;
        data_en_nxt = 1'b0;
        perr_nxt    = 1'b0;
        ferr_nxt    = 1'b0;
        tmo_nxt     = tmo_cnt;
        tmo_hit_c   = (state != S_IDLE) && (tmo_cnt == TCNT_W'(TIMEOUT_CYCLES));

        if (fall_c || state == S_IDLE) begin
            tmo_nxt = '0;
        end else if (tmo_cnt != TCNT_W'(TIMEOUT_CYCLES)) begin
            tmo_nxt = tmo_cnt + TCNT_W'(1);
        end

        if (fall_c) begin
            case (state)
                S_IDLE: begin
                    if (!dat_s2) begin
                        state_nxt   = S_DATA;
                        bit_cnt_nxt = '0;
                    end
                end
                S_DATA: begin
                    shift_nxt   = {dat_s2, shift[7:1]};
                    bit_cnt_nxt = bit_cnt + BCNT_W'(1);
                    if (bit_cnt == BCNT_W'(7)) begin
                        state_nxt = S_PARITY;
                    end
                end
                S_PARITY: begin
                    par_nxt   = dat_s2;
                    state_nxt = S_STOP;
                end
                S_STOP: begin
                    state_nxt   = S_IDLE;
                    bit_cnt_nxt = '0;
                    if (!dat_s2) begin
                        ferr_nxt = 1'b1;
                    end else if (^{shift, par_bit} != 1'b1) begin
                        perr_nxt = 1'b1;
                    end else begin
                        data_nxt    = shift;
                        data_en_nxt = 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end else if (tmo_hit_c) begin
            state_nxt   = S_IDLE;
            bit_cnt_nxt = '0;
            ferr_nxt    = 1'b1;
        end

        busy_nxt = (state_nxt != S_IDLE);
    end

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: directed frames, error frames, timeout,
// clock glitches, mid-frame reset and randomised frames against a frame model.
`timescale 1ns/1ps
module tb_ps2_rx;

    localparam int unsigned FILTER_LEN = 8;
    localparam int unsigned TIMEOUT    = 1000;
    localparam int          HALF       = 100;   // 40 us half period at 400 ns clock

    logic       Clock   = 1'b0;
    logic       nReset  = 1'b0;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DAT = 1'b1;
    logic [7:0] data;
    logic       data_en, parity_err, frame_err, busy;

    int n_assert = 0;
    int n_fail   = 0;

    int en_cnt = 0, perr_cnt = 0, ferr_cnt = 0, both_cnt = 0;
    int base_en, base_perr, base_ferr;
    logic [7:0] en_data = 8'h00;

    ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .Clock     (Clock),
        .nReset    (nReset),
        .PS2_CLK   (PS2_CLK),
        .PS2_DAT   (PS2_DAT),
        .data      (data),
        .data_en   (data_en),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #200 Clock = ~Clock;

    // Pulse monitor: counts strobe cycles and captures data on data_en
    always @(negedge Clock) begin
        if (data_en) begin
            en_cnt  <= en_cnt + 1;
            en_data <= data;
        end
        if (parity_err) perr_cnt <= perr_cnt + 1;
        if (frame_err)  ferr_cnt <= ferr_cnt + 1;
        if (data_en && (parity_err || frame_err)) both_cnt <= both_cnt + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic odd_par(input logic [7:0] b);
        return ~(^b);
    endfunction

    function automatic logic [10:0] mk(input logic [7:0] b, input logic p, input logic s);
        return {s, p, b, 1'b0};
    endfunction

    task automatic snap();
        base_en   = en_cnt;
        base_perr = perr_cnt;
        base_ferr = ferr_cnt;
    endtask

    // Device side: data set while clock high, receiver samples on the fall
    task automatic send(input logic [10:0] fr, input int nbits, input bit glitch,
                        output logic busy_mid);
        busy_mid = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            PS2_DAT = fr[i];
            if (glitch) begin
                wait_clk(HALF / 2);
                PS2_CLK = 1'b0;
                wait_clk(3);
                PS2_CLK = 1'b1;
                wait_clk(HALF / 2 - 3);
            end else begin
                wait_clk(HALF);
            end
            PS2_CLK = 1'b0;
            wait_clk(HALF / 2);
            if (i == 4) busy_mid = busy;
            wait_clk(HALF / 2);
            PS2_CLK = 1'b1;
        end
        wait_clk(HALF);
        PS2_DAT = 1'b1;
    endtask

    task automatic check_frame(input string tag, input int e_en, input int e_perr,
                               input int e_ferr, input logic [7:0] e_data);
        chk({tag, ".en"},   32'(en_cnt - base_en),     32'(e_en));
        chk({tag, ".perr"}, 32'(perr_cnt - base_perr), 32'(e_perr));
        chk({tag, ".ferr"}, 32'(ferr_cnt - base_ferr), 32'(e_ferr));
        chk({tag, ".data"}, 32'(data), 32'(e_data));
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        if (e_en > 0) chk({tag, ".en_data"}, 32'(en_data), 32'(e_data));
    endtask

    initial begin
        logic       bm;
        logic [7:0] b;
        logic       p, s;
        int         kind;
        logic [7:0] exp_data;
        int         e_en, e_perr, e_ferr;

        // Reset values
        wait_clk(5);
        chk("rst.data",  32'(data), 32'h00);
        chk("rst.en",    32'(data_en), 32'd0);
        chk("rst.perr",  32'(parity_err), 32'd0);
        chk("rst.ferr",  32'(frame_err), 32'd0);
        chk("rst.busy",  32'(busy), 32'd0);
        nReset = 1'b1;
        wait_clk(20);

        // Clean 0x16, busy during frame
        snap();
        send(mk(8'h16, 1'b0, 1'b1), 11, 1'b0, bm);
        wait_clk(2 * HALF);
        chk("f16.busy_mid", 32'(bm), 32'd1);
        check_frame("f16", 1, 0, 0, 8'h16);

        // Back-to-back 0xF0, 0x5A
        snap();
        send(mk(8'hF0, odd_par(8'hF0), 1'b1), 11, 1'b0, bm);
        chk("fF0.en_data", 32'(en_data), 32'hF0);
        send(mk(8'h5A, 1'b1, 1'b1), 11, 1'b0, bm);
        wait_clk(2 * HALF);
        check_frame("f5A", 2, 0, 0, 8'h5A);

        // Bad parity on 0x1E
        snap();
        send(mk(8'h1E, 1'b0, 1'b1), 11, 1'b0, bm);
        wait_clk(2 * HALF);
        check_frame("f1E_par", 0, 1, 0, 8'h5A);

        // Bad stop on 0x45, then clean 0x45
        snap();
        send(mk(8'h45, 1'b0, 1'b0), 11, 1'b0, bm);
        wait_clk(2 * HALF);
        check_frame("f45_stop", 0, 0, 1, 8'h5A);
        snap();
        send(mk(8'h45, 1'b0, 1'b1), 11, 1'b0, bm);
        wait_clk(2 * HALF);
        check_frame("f45", 1, 0, 0, 8'h45);

        // Partial frame: start + 4 data bits then idle -> timeout
        snap();
        send(mk(8'h0B, 1'b0, 1'b1), 5, 1'b0, bm);
        wait_clk(TIMEOUT - 250);
        chk("tmo.early_ferr", 32'(ferr_cnt - base_ferr), 32'd0);
        chk("tmo.early_busy", 32'(busy), 32'd1);
        wait_clk(150);
        check_frame("tmo", 0, 0, 1, 8'h45);
        snap();
        send(mk(8'h26, odd_par(8'h26), 1'b1), 11, 1'b0, bm);
        wait_clk(2 * HALF);
        check_frame("f26", 1, 0, 0, 8'h26);

        // Short low glitches on PS2_CLK during 0x3D
        snap();
        send(mk(8'h3D, odd_par(8'h3D), 1'b1), 11, 1'b1, bm);
        wait_clk(2 * HALF);
        check_frame("f3D_glitch", 1, 0, 0, 8'h3D);

        // Randomised frames against the frame-rule model
        exp_data = 8'h3D;
        for (int k = 0; k < 6; k++) begin
            b    = 8'($urandom);
            kind = int'($urandom_range(0, 3));
            p    = odd_par(b) ^ (kind == 0);
            s    = (kind == 1) ? 1'b0 : 1'b1;
            e_en = 0; e_perr = 0; e_ferr = 0;
            if (!s)                          e_ferr = 1;
            else if ($countones({b, p}) % 2 != 1) e_perr = 1;
            else begin e_en = 1; exp_data = b; end
            snap();
            send(mk(b, p, s), 11, 1'b0, bm);
            wait_clk(2 * HALF);
            check_frame($sformatf("rnd%0d", k), e_en, e_perr, e_ferr, exp_data);
        end

        // Reset mid-frame: outputs clear, no strobe, fresh frame accepted after
        snap();
        send(mk(8'hA7, odd_par(8'hA7), 1'b1), 5, 1'b0, bm);
        nReset = 1'b0;
        wait_clk(3);
        chk("mrst.data", 32'(data), 32'h00);
        chk("mrst.en",   32'(data_en), 32'd0);
        chk("mrst.perr", 32'(parity_err), 32'd0);
        chk("mrst.ferr", 32'(frame_err), 32'd0);
        chk("mrst.busy", 32'(busy), 32'd0);
        nReset = 1'b1;
        wait_clk(TIMEOUT + 500);
        check_frame("mrst_idle", 0, 0, 0, 8'h00);
        b = 8'($urandom);
        snap();
        send(mk(b, odd_par(b), 1'b1), 11, 1'b0, bm);
        wait_clk(2 * HALF);
        check_frame("post_rst", 1, 0, 0, b);

        chk("mutex", 32'(both_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
